// File: rtl/video_ula.sv
// Video ULA: CRTC character clock, framestore byte capture, palette serialiser with flash/cursor/teletext.
// Latency: one clk16 register stage from shift register to rgb; free-running, no backpressure.
module video_ula (
    input  logic       clk16,
    input  logic       nRESET,
    input  logic       cpu_wr,
    input  logic       cpu_a0,
    input  logic [7:0] cpu_data,
    input  logic [7:0] ram_data,
    input  logic       display_en,
    input  logic       cursor,
    input  logic [2:0] ttx_rgb,
    output logic       char_clk,
    output logic [2:0] rgb
);
    logic [7:0] r_ctrl;
    logic [3:0] r_pal [16];
    logic [3:0] r_cnt;
    logic [7:0] r_shift;
    logic       r_de_q;
    logic [3:0] r_cur;
    logic [2:0] r_rgb;

    logic       w_fast;
    logic       w_load;
    logic       w_pix;
    logic       w_cur_inv;
    logic [3:0] w_lcol;
    logic [3:0] w_p;
    logic [2:0] w_c;

    assign w_fast   = r_ctrl[4];
    assign char_clk = w_fast ? r_cnt[2] : r_cnt[3];
    // Load sits on the last count of a character so char_clk falls right after it.
    assign w_load   = w_fast ? (r_cnt[2:0] == 3'h7) : (r_cnt == 4'hF);

    always_comb begin
        case (r_ctrl[3:2])
            2'b00:   w_pix = &r_cnt[2:0];
            2'b01:   w_pix = &r_cnt[1:0];
            2'b10:   w_pix = r_cnt[0];
            default: w_pix = 1'b1;
        endcase
    end

    assign w_lcol    = {r_shift[7], r_shift[5], r_shift[3], r_shift[1]};
    assign w_p       = r_pal[w_lcol];
    assign w_cur_inv = (r_ctrl[7] & r_cur[0]) | (r_ctrl[6] & r_cur[1])
                     | (r_ctrl[5] & (r_cur[2] | r_cur[3]));

    always_comb begin
        w_c = ~w_p[2:0];
        if (w_p[3] && r_ctrl[0])
            w_c = w_p[2:0];
        if (r_ctrl[1])
            w_c = ttx_rgb;
        else if (!r_de_q)
            w_c = 3'b000;
        // Cursor inversion overrides blanking and teletext alike.
        if (w_cur_inv)
            w_c = w_c ^ 3'b111;
    end

    always_ff @(posedge clk16) begin
        if (!nRESET) begin
            r_ctrl <= 8'h00;
            for (int i = 0; i < 16; i++)
                r_pal[i] <= 4'h0;
        end else if (cpu_wr) begin
            if (cpu_a0)
                r_pal[cpu_data[7:4]] <= cpu_data[3:0];
            else
                r_ctrl <= cpu_data;
        end
    end

    always_ff @(posedge clk16) begin
        if (!nRESET) begin
            r_cnt   <= 4'h0;
            r_shift <= 8'h00;
            r_de_q  <= 1'b0;
            r_cur   <= 4'h0;
            r_rgb   <= 3'b000;
        end else begin
            r_cnt <= r_cnt + 4'd1;
            r_rgb <= w_c;
            if (w_load) begin
                r_shift <= display_en ? ram_data : 8'h00;
                r_de_q  <= display_en;
                r_cur   <= {r_cur[2:0], cursor};
            end else if (w_pix) begin
                r_shift <= {r_shift[6:0], 1'b1};
            end
        end
    end

    assign rgb = r_rgb;
endmodule

// File: tb/tb_video_ula.sv
// Scoreboard bench for video_ula: expected pixels queued per character load, compared against rgb.
`timescale 1ns/1ps
module tb_video_ula;
    logic       clk16 = 1'b0;
    logic       nRESET;
    logic       cpu_wr;
    logic       cpu_a0;
    logic [7:0] cpu_data;
    logic [7:0] ram_data;
    logic       display_en;
    logic       cursor;
    logic [2:0] ttx_rgb;
    logic       char_clk;
    logic [2:0] rgb;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] tb_cnt;
    logic [3:0] cur_m;
    logic [7:0] ctrl_q;
    logic [7:0] ctrl_m;
    logic [3:0] pal_m [16];

    logic [2:0] exp_q [$];
    logic [2:0] obs_q [$];
    logic [7:0] ch_ram [$];
    logic       ch_de [$];
    logic       ch_cur [$];

    video_ula dut (
        .clk16     (clk16),
        .nRESET    (nRESET),
        .cpu_wr    (cpu_wr),
        .cpu_a0    (cpu_a0),
        .cpu_data  (cpu_data),
        .ram_data  (ram_data),
        .display_en(display_en),
        .cursor    (cursor),
        .ttx_rgb   (ttx_rgb),
        .char_clk  (char_clk),
        .rgb       (rgb)
    );

    always #5 clk16 = ~clk16;

    // Bench-side divider and cursor pipe, used to know where loads fall.
    always @(posedge clk16) begin
        if (!nRESET) begin
            tb_cnt <= 4'd0;
            cur_m  <= 4'd0;
            ctrl_q <= 8'd0;
        end else begin
            tb_cnt <= tb_cnt + 4'd1;
            if (ctrl_q[4] ? (tb_cnt[2:0] == 3'd7) : (tb_cnt == 4'd15))
                cur_m <= {cur_m[2:0], cursor};
            if (cpu_wr && !cpu_a0)
                ctrl_q <= cpu_data;
        end
    end

    function automatic logic [2:0] model_rgb(input logic [7:0] s, input logic de,
                                             input logic [3:0] cur, input logic [7:0] ctl);
        logic [3:0] l;
        logic [3:0] p;
        logic [2:0] c;
        l = {s[7], s[5], s[3], s[1]};
        p = pal_m[l];
        c = ~p[2:0];
        if (p[3] && ctl[0]) c = p[2:0];
        if (ctl[1]) c = ttx_rgb;
        else if (!de) c = 3'b000;
        if ((ctl[7] && cur[0]) || (ctl[6] && cur[1]) || (ctl[5] && (cur[2] || cur[3])))
            c = ~c;
        return c;
    endfunction

    task automatic cpu_write(input logic a0, input logic [7:0] d);
        cpu_wr = 1'b1; cpu_a0 = a0; cpu_data = d;
        if (a0) pal_m[d[7:4]] = d[3:0];
        else    ctrl_m = d;
        @(negedge clk16);
        cpu_wr = 1'b0;
    endtask

    task automatic add_char(input logic [7:0] r, input logic de, input logic cur);
        ch_ram.push_back(r); ch_de.push_back(de); ch_cur.push_back(cur);
    endtask

    // Drives queued characters on successive fast-mode loads; pushes expected and observed pixels.
    task automatic run_chars();
        int n, ci, mask;
        logic [7:0] s;
        logic [3:0] cn;
        n = ch_ram.size();
        exp_q.delete(); obs_q.delete();
        for (int g = 0; g < 16 && tb_cnt[2:0] != 3'd7; g++) @(negedge clk16);
        for (int t = 0; t < n * 8 + 2; t++) begin
            if (t >= 2) obs_q.push_back(rgb);
            if (t % 8 == 0 && t / 8 < n) begin
                ci = t / 8;
                ram_data = ch_ram[ci]; display_en = ch_de[ci]; cursor = ch_cur[ci];
                cn   = {cur_m[2:0], ch_cur[ci]};
                s    = ch_de[ci] ? ch_ram[ci] : 8'h00;
                mask = (1 << (3 - int'(ctrl_m[3:2]))) - 1;
                for (int j = 0; j < 8; j++) begin
                    exp_q.push_back(model_rgb(s, ch_de[ci], cn, ctrl_m));
                    if (j != 7 && ((j & mask) == mask)) s = {s[6:0], 1'b1};
                end
            end
            @(negedge clk16);
        end
        display_en = 1'b0; cursor = 1'b0;
        ch_ram.delete(); ch_de.delete(); ch_cur.delete();
    endtask

    task automatic test_reset();
        nRESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cpu_wr = 1'($urandom); cpu_a0 = 1'($urandom); cpu_data = 8'($urandom);
            ram_data = 8'($urandom); display_en = 1'($urandom); cursor = 1'($urandom);
            ttx_rgb = 3'($urandom);
            @(negedge clk16);
            n_checks++;
            if (rgb !== 3'b000 || char_clk !== 1'b0)
                $display("FAIL reset cyc%0d: rgb=%b char_clk=%b, required 000/0", i, rgb, char_clk);
            else n_pass++;
        end
        nRESET = 1'b1; cpu_wr = 1'b0; display_en = 1'b0; cursor = 1'b0; ttx_rgb = 3'b000;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (char_clk !== (i >= 8))
                $display("FAIL reset_charclk cyc%0d: char_clk=%b required %b", i, char_clk, i >= 8);
            else n_pass++;
            @(negedge clk16);
        end
        n_checks++;
        if (rgb !== 3'b000) $display("FAIL reset_rgb: rgb=%b required 000", rgb);
        else n_pass++;
    endtask

    task automatic test_divider();
        cpu_write(1'b0, 8'h1C);
        for (int g = 0; g < 16 && tb_cnt[2:0] != 3'd0; g++) @(negedge clk16);
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (char_clk !== ((i % 8) >= 4))
                $display("FAIL divider cyc%0d: char_clk=%b required %b", i, char_clk, (i % 8) >= 4);
            else n_pass++;
            @(negedge clk16);
        end
    endtask

    task automatic test_serialise();
        logic [2:0] e, o;
        logic [2:0] tp [4];
        tp = '{3'b110, 3'b000, 3'b110, 3'b111};
        cpu_write(1'b1, 8'hF1); cpu_write(1'b1, 8'h07); cpu_write(1'b0, 8'h1C);
        add_char(8'hAA, 1'b1, 1'b0); add_char(8'hAA, 1'b1, 1'b0);
        run_chars();
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL serialise px%0d: rgb=%b required %b", i, o, e);
            else n_pass++;
            if (i < 4) begin
                n_checks++;
                if (o !== tp[i]) $display("FAIL serialise_const px%0d: rgb=%b required %b", i, o, tp[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_blank();
        logic [2:0] o;
        add_char(8'hAA, 1'b0, 1'b0); add_char(8'h00, 1'b0, 1'b0);
        run_chars();
        for (int i = 0; exp_q.size() > 0; i++) begin
            void'(exp_q.pop_front()); o = obs_q.pop_front();
            n_checks++;
            if (o !== 3'b000) $display("FAIL blank px%0d: rgb=%b required 000", i, o);
            else n_pass++;
        end
    endtask

    task automatic test_rates();
        logic [2:0] e, o;
        logic [7:0] ctl [3];
        ctl = '{8'h18, 8'h14, 8'h10};
        for (int i = 0; i < 16; i++) cpu_write(1'b1, {4'(i), 4'(i * 7 + 3)});
        for (int r = 0; r < 3; r++) begin
            cpu_write(1'b0, ctl[r]);
            add_char(8'hC3, 1'b1, 1'b0); add_char(8'h5A, 1'b1, 1'b0); add_char(8'h96, 1'b1, 1'b0);
            run_chars();
            for (int i = 0; exp_q.size() > 0; i++) begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                n_checks++;
                if (o !== e) $display("FAIL rate_%h px%0d: rgb=%b required %b", ctl[r], i, o, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_flash();
        logic [2:0] e, o, k;
        cpu_write(1'b1, 8'hF9);
        for (int f = 1; f >= 0; f--) begin
            cpu_write(1'b0, f == 1 ? 8'h1D : 8'h1C);
            k = (f == 1) ? 3'b001 : 3'b110;
            add_char(8'hFF, 1'b1, 1'b0);
            run_chars();
            for (int i = 0; exp_q.size() > 0; i++) begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                n_checks++;
                if (o !== e || o !== k)
                    $display("FAIL flash%0d px%0d: rgb=%b required %b", f, i, o, k);
                else n_pass++;
            end
        end
    endtask

    task automatic test_cursor();
        logic [2:0] e, o, k;
        cpu_write(1'b0, 8'h9C);
        for (int c = 0; c < 5; c++) add_char(8'hFF, 1'b1, c == 1);
        run_chars();
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            k = (i / 8 == 1) ? 3'b001 : 3'b110;
            n_checks++;
            if (o !== e || o !== k) $display("FAIL cursor_9c px%0d: rgb=%b required %b", i, o, k);
            else n_pass++;
        end
        cpu_write(1'b0, 8'h3C);
        for (int c = 0; c < 5; c++) add_char(8'hFF, 1'b1, c == 0);
        run_chars();
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            k = (i / 8 == 2 || i / 8 == 3) ? 3'b001 : 3'b110;
            n_checks++;
            if (o !== e || o !== k) $display("FAIL cursor_3c px%0d: rgb=%b required %b", i, o, k);
            else n_pass++;
        end
        ttx_rgb = 3'b101;
        cpu_write(1'b0, 8'h1E);
        add_char(8'h5A, 1'b0, 1'b0); add_char(8'hFF, 1'b1, 1'b0);
        run_chars();
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e || o !== 3'b101) $display("FAIL teletext px%0d: rgb=%b required 101", i, o);
            else n_pass++;
        end
        ttx_rgb = 3'b000;
    endtask

    task automatic test_pal_write();
        logic [2:0] old_c, new_c;
        cpu_write(1'b0, 8'h1C);
        ram_data = 8'hFF; display_en = 1'b1;
        repeat (20) @(negedge clk16);
        old_c = model_rgb(8'hFF, 1'b1, cur_m, ctrl_m);
        cpu_write(1'b1, 8'hF2);
        new_c = model_rgb(8'hFF, 1'b1, cur_m, ctrl_m);
        n_checks++;
        if (rgb !== old_c) $display("FAIL pal_write_before: rgb=%b required %b", rgb, old_c);
        else n_pass++;
        @(negedge clk16);
        n_checks++;
        if (rgb !== new_c) $display("FAIL pal_write_after: rgb=%b required %b", rgb, new_c);
        else n_pass++;
        display_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2:0] e, o;
        for (int i = 0; i < 16; i++) cpu_write(1'b1, {4'(i), 4'($urandom)});
        for (int r = 0; r < 3; r++) begin
            ttx_rgb = 3'($urandom);
            cpu_write(1'b0, {3'($urandom), 1'b1, 2'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom)});
            for (int c = 0; c < 8; c++)
                add_char(8'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0));
            run_chars();
            for (int i = 0; exp_q.size() > 0; i++) begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                n_checks++;
                if (o !== e) $display("FAIL b2b_%0d px%0d: rgb=%b required %b ctrl=%h", r, i, o, e, ctrl_m);
                else n_pass++;
            end
        end
    endtask

    initial begin
        ctrl_m = 8'h00;
        for (int i = 0; i < 16; i++) pal_m[i] = 4'h0;
        cpu_wr = 1'b0; cpu_a0 = 1'b0; cpu_data = 8'h00; ram_data = 8'h00;
        display_en = 1'b0; cursor = 1'b0; ttx_rgb = 3'b000; nRESET = 1'b0;
        test_reset();
        test_divider();
        test_serialise();
        test_blank();
        test_rates();
        test_flash();
        test_cursor();
        test_pal_write();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
